// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide unit
package multdiv_pkg;

   localparam int DATA_W = 32;
   localparam int ITER = 32;
   localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

   // processor ALU opcodes that the decoder turns into start pulses
   localparam logic [4:0] ALU_OP_MUL = 5'b00110;
   localparam logic [4:0] ALU_OP_DIV = 5'b00111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// rtl/multdiv_unit_div_step.sv - one combinational restoring-division step on magnitudes
module div_step
   import multdiv_pkg::*;
(
   input  logic [2*DATA_W-1:0] rq,
   input  logic [DATA_W-1:0]   divisor,
   output logic [2*DATA_W-1:0] rq_next
);

   logic [DATA_W:0] trial;
   logic [DATA_W:0] diff;

   // trial is the remainder after the left shift; one extra bit keeps the borrow visible
   always_comb begin
      trial = rq[2*DATA_W-1:DATA_W-1];
      diff  = trial - {1'b0, divisor};
      if (diff[DATA_W])
         rq_next = {trial[DATA_W-1:0], rq[DATA_W-2:0], 1'b0};
      else
         rq_next = {diff[DATA_W-1:0], rq[DATA_W-2:0], 1'b1};
   end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - sequential signed 32-bit Booth multiply / restoring divide
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_MULT,
   input  logic              ctrl_DIV,
   input  logic [DATA_W-1:0] data_operandA,
   input  logic [DATA_W-1:0] data_operandB,
   output logic [DATA_W-1:0] data_result,
   output logic              data_exception,
   output logic              data_resultRDY
);

   localparam logic [4:0] LAST = 5'(ITER - 1);

   state_t state, state_nxt;
   logic [4:0]          count;
   logic                last;
   logic [DATA_W-1:0]   mcand;
   logic [DATA_W-1:0]   divisor;
   logic [2*DATA_W:0]   prod, prod_nxt;
   logic [DATA_W:0]     booth_sum;
   logic [2*DATA_W-1:0] rq, rq_nxt;
   logic                quo_neg, div_zero, div_ovf;
   logic                mul_ovf;
   logic [DATA_W-1:0]   a_mag, b_mag, quo_signed;

   assign last           = (count == LAST);
   assign data_resultRDY = (state == ST_DONE);
   assign a_mag          = data_operandA[DATA_W-1] ? -data_operandA : data_operandA;
   assign b_mag          = data_operandB[DATA_W-1] ? -data_operandB : data_operandB;

   // accumulator is widened to 33 bits so INT_MIN multiplicands cannot overflow it
   always_comb begin
      booth_sum = {prod[2*DATA_W], prod[2*DATA_W:DATA_W+1]};
      case (prod[1:0])
         2'b01:   booth_sum = booth_sum + {mcand[DATA_W-1], mcand};
         2'b10:   booth_sum = booth_sum - {mcand[DATA_W-1], mcand};
         default: ;
      endcase
      prod_nxt = {booth_sum, prod[DATA_W:1]};
   end

   assign mul_ovf = (prod_nxt[2*DATA_W:DATA_W+1] != {DATA_W{prod_nxt[DATA_W]}});

   div_step u_div_step (
      .rq      (rq),
      .divisor (divisor),
      .rq_next (rq_nxt)
   );

   assign quo_signed = quo_neg ? -rq_nxt[DATA_W-1:0] : rq_nxt[DATA_W-1:0];

   // a start pulse in any state restarts; multiply has priority over divide
   always_comb begin
      state_nxt = state;
      if (ctrl_MULT)
         state_nxt = ST_MUL;
      else if (ctrl_DIV)
         state_nxt = ST_DIV;
      else begin
         case (state)
            ST_MUL, ST_DIV: if (last) state_nxt = ST_DONE;
            ST_DONE:        state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         count          <= '0;
         mcand          <= '0;
         divisor        <= '0;
         prod           <= '0;
         rq             <= '0;
         quo_neg        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ctrl_MULT) begin
            mcand <= data_operandA;
            prod  <= {{DATA_W{1'b0}}, data_operandB, 1'b0};
            count <= '0;
         end else if (ctrl_DIV) begin
            divisor  <= b_mag;
            rq       <= {{DATA_W{1'b0}}, a_mag};
            quo_neg  <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            count    <= '0;
         end else if (state == ST_MUL || state == ST_DIV) begin
            if (state == ST_MUL)
               prod <= prod_nxt;
            else
               rq <= rq_nxt;
            if (!last)
               count <= count + 5'd1;
            else if (state == ST_MUL) begin
               data_result    <= prod_nxt[DATA_W:1];
               data_exception <= mul_ovf;
            end else if (div_zero) begin
               data_result    <= '0;
               data_exception <= 1'b1;
            end else if (div_ovf) begin
               data_result    <= INT_MIN;
               data_exception <= 1'b1;
            end else begin
               data_result    <= quo_signed;
               data_exception <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed-vector bench for multdiv_unit
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_operandA, data_operandB;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   int vectors = 0;
   int miscompares = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // caller sits just after a falling edge; returns at the falling edge inside the RDY cycle
   task automatic run_op(input string tag, input bit mul, input bit both,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit exp_exc);
      int lat;
      lat           = 0;
      ctrl_MULT     = mul;
      ctrl_DIV      = !mul || both;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      do begin
         @(negedge clock);
         lat++;
      end while (!data_resultRDY && lat < 40);
      check({tag, ".latency"}, 32'(lat), 32'd33);
      check({tag, ".result"}, data_result, exp_res);
      check({tag, ".exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
   endtask

   task automatic hold_check(input string tag, input logic [31:0] exp_res, input bit exp_exc);
      @(negedge clock);
      check({tag, ".rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
      check({tag, ".held"}, data_result, exp_res);
      check({tag, ".held_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
   endtask

   initial begin
      int pulses;
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(negedge clock);
      check("reset.result", data_result, 32'd0);
      check("reset.exc", {31'd0, data_exception}, 32'd0);
      check("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op("mul_7_m3", 1, 0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 0);
      run_op("div_m17_5_b2b", 0, 0, -32'sd17, 32'd5, 32'hFFFF_FFFD, 0);
      hold_check("div_m17_5", 32'hFFFF_FFFD, 0);

      run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
      hold_check("mul_ovf", 32'h0000_0000, 1);

      run_op("div_by_zero", 0, 0, 32'd9, 32'd0, 32'd0, 1);
      hold_check("div_by_zero", 32'd0, 1);

      run_op("div_intmin_m1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      hold_check("div_intmin_m1", 32'h8000_0000, 1);

      run_op("div_7_m2", 0, 0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 0);
      hold_check("div_7_m2", 32'hFFFF_FFFD, 0);

      run_op("both_starts", 1, 1, 32'd3, 32'd4, 32'd12, 0);
      hold_check("both_starts", 32'd12, 0);

      // multiply aborted by a divide issued 10 cycles later
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd6;
      data_operandB = 32'd7;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      pulses    = 0;
      repeat (9) begin
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
      check("abort.early_rdy", 32'(pulses), 32'd0);
      run_op("abort_div_100_7", 0, 0, 32'd100, 32'd7, 32'd14, 0);
      hold_check("abort_div_100_7", 32'd14, 0);

      // reset in the middle of a multiply
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd11;
      data_operandB = 32'd13;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      repeat (15) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midreset.result", data_result, 32'd0);
      check("midreset.exc", {31'd0, data_exception}, 32'd0);
      check("midreset.rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset  = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
      check("midreset.no_rdy", 32'(pulses), 32'd0);

      run_op("mul_intmin_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      hold_check("mul_intmin_m1", 32'h8000_0000, 1);
      run_op("mul_m5_m5", 1, 0, -32'sd5, -32'sd5, 32'd25, 0);
      hold_check("mul_m5_m5", 32'd25, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Sequential signed 32-bit multiply/divide unit alongside the single-cycle processor's ALU. The processor issues a one-cycle start pulse with two operands. The unit iterates for a fixed 32 cycles, then returns a 32-bit result, an exception flag and a one-cycle ready pulse. The processor stalls its PC and regfile write for `mul`/`div` until that ready pulse arrives.

## Interface
No parameters; width fixed at 32.
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ctrl_MULT  in  1  one-cycle start pulse for signed multiply
- ctrl_DIV  in  1  one-cycle start pulse for signed divide
- data_operandA  in  32  multiplicand / dividend, sampled only on a start edge
- data_operandB  in  32  multiplier / divisor, sampled only on a start edge
- data_result  out  32  low 32 bits of product, or quotient; held until next start
- data_exception  out  1  overflow or divide-by-zero; valid with data_resultRDY, held with data_result
- data_resultRDY  out  1  high for exactly one cycle when data_result is valid

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL on ctrl_MULT; IDLE → DIV on ctrl_DIV. Operands are latched on the same edge and the iteration counter is cleared.
- Both ctrl_MULT and ctrl_DIV high: multiply wins, divide is ignored.
- A start pulse in MUL, DIV or DONE aborts the current operation and restarts with the new operands. No RDY is issued for the aborted operation.
- MUL: radix-2 Booth, 65-bit product register {A-acc, multiplier, extra bit}, one arithmetic shift per cycle, 32 cycles.
  - Exception when the full 64-bit product is not the sign-extension of its low 32 bits.
- DIV: restoring division on magnitudes, 64-bit {remainder, quotient} register, one subtract/shift per cycle, 32 cycles.
  - Quotient is negated if the operand signs differ; truncates toward zero; remainder is discarded.
- Divisor 0: data_result = 0, data_exception = 1. Timing is unchanged (still 32 iterations).
- 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- MUL/DIV → DONE when the counter reaches 31. In DONE the unit drives data_resultRDY = 1 and updates data_result and data_exception.
- DONE → IDLE on the next edge unless a new start is present.
- data_result and data_exception change only on entry to DONE or on reset.

## Timing
- Start sampled at edge E0. Iterations run on edges E1..E32. data_resultRDY is high during the cycle after E32, i.e. a result is available 33 cycles after the start edge.
- Back-to-back: a start coincident with the RDY cycle is accepted. Its RDY follows 33 cycles later.
- Operand inputs are don't-care outside start cycles.
- Reset values: data_result = 0, data_exception = 0, data_resultRDY = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation: outputs clear asynchronously and no RDY follows. After release, the unit waits in IDLE for a fresh start.
- Counter is 5 bits and must not wrap past 31 into a second pass.

## Structure
- Shared package `multdiv_pkg` holds:
  - state enum
  - processor ALU opcodes for mul (00110) and div (00111), used by the processor to generate the start pulses
  - constants: DATA_W = 32, ITER = 32, INT_MIN = 32'h8000_0000
- One natural sub-module, `div_step`: combinational restoring step, taking {rem, quo} and the divisor and producing the next {rem, quo}.
- Booth step, FSM and output registers stay in the top module.

## Test plan
- ctrl_MULT, A = 7, B = −3 → after exactly 33 cycles RDY pulses once, result 0xFFFFFFEB, exception 0.
- ctrl_MULT, A = 0x00010000, B = 0x00010000 → result 0x00000000, exception 1 (overflow).
- ctrl_DIV, A = −17, B = 5 → result 0xFFFFFFFD (−3), exception 0. Then A = 9, B = 0 → result 0, exception 1, still 33-cycle latency.
- ctrl_DIV, A = 0x80000000, B = 0xFFFFFFFF → result 0x80000000, exception 1.
- ctrl_MULT (6×7) then ctrl_DIV (100/7) issued 10 cycles later → only one RDY, 33 cycles after the divide start, result 14.
- Reset pulsed at cycle 15 of a multiply → all outputs 0 immediately, no RDY afterward. A new ctrl_MULT after release completes normally.
